// File: rtl/nonoverlap_clkgen_ctrl.sv
// nonoverlap_clkgen_ctrl
// Produces a two-phase non-overlapping clock pair (MOD / MODN) separated by
// programmable dead time, plus a slow clock (MODL) that toggles every DIV
// periods. The timing configuration can be changed at run time. A change is
// staged and takes effect at the next period boundary, so the current period
// always finishes with consistent timing.
//
// Ports
//   CLK_IN, RST_N_IN      clock, asynchronous active-low reset
//   EN_IN                 run request (level); sampled in IDLE and at each boundary
//   CFG_VALID_IN/READY_OUT configuration handshake
//   CFG_HALF_IN           high-phase length in cycles (0 is rejected)
//   CFG_DEAD_IN           dead-time length in cycles (0 removes the dead phases)
//   CFG_DIV_IN            MODL divider in periods (0 behaves as 1)
//   CLK_OUT_MOD/MODN      non-overlapping phase clocks
//   CLK_OUT_MODL          slow clock
//   BUSY_OUT              FSM not in IDLE
//   PERIOD_TICK_OUT       high on the last cycle of every period
//   CFG_ERR_OUT           one-cycle pulse after a rejected transfer
//   STATE_DBG_OUT         current FSM state, for observation
//
// Handshake: a configuration transfer happens at a rising edge where
// CFG_VALID_IN and CFG_READY_OUT are both high. READY does not depend on
// VALID. The source holds its data stable while VALID is high and READY is low.
module nonoverlap_clkgen_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned HALF_DEF = 12,
    parameter int unsigned DEAD_DEF = 4,
    parameter int unsigned DIV_DEF  = 1
) (
    input  logic             CLK_IN,
    input  logic             RST_N_IN,
    input  logic             EN_IN,
    input  logic             CFG_VALID_IN,
    output logic             CFG_READY_OUT,
    input  logic [CNT_W-1:0] CFG_HALF_IN,
    input  logic [CNT_W-1:0] CFG_DEAD_IN,
    input  logic [CNT_W-1:0] CFG_DIV_IN,
    output logic             CLK_OUT_MOD,
    output logic             CLK_OUT_MODN,
    output logic             CLK_OUT_MODL,
    output logic             BUSY_OUT,
    output logic             PERIOD_TICK_OUT,
    output logic             CFG_ERR_OUT,
    output logic [2:0]       STATE_DBG_OUT
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PH_MOD  = 3'd1,
        ST_DEAD1   = 3'd2,
        ST_PH_MODN = 3'd3,
        ST_DEAD2   = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_q, dead_q, div_q;
    logic [CNT_W-1:0] half_n, dead_n, div_n;
    logic [CNT_W-1:0] stg_half_q, stg_dead_q, stg_div_q;
    logic [CNT_W-1:0] stg_half_d, stg_dead_d, stg_div_d;
    logic             stg_vld_q, stg_vld_d;
    logic [CNT_W-1:0] pcnt_q, pcnt_d;
    logic             modl_q, modl_d;
    logic             mod_q, modn_q, busy_q, tick_q, err_q, ready_q;
    logic             tick_d, ready_d;

    logic             xfer, xfer_ok, xfer_bad;
    logic [CNT_W-1:0] in_div;
    logic             boundary, apply;

    assign xfer     = CFG_VALID_IN && ready_q;
    assign xfer_ok  = xfer && (CFG_HALF_IN != '0);
    assign xfer_bad = xfer && (CFG_HALF_IN == '0);
    assign in_div   = (CFG_DIV_IN == '0) ? ONE : CFG_DIV_IN;

    // Last cycle of a period: end of DEAD2, or end of PH_MODN when DEAD is 0.
    assign boundary = (cnt_q == '0) &&
                      ((state_q == ST_DEAD2) ||
                       ((state_q == ST_PH_MODN) && (dead_q == '0)));
    // The active config can change only between periods (IDLE or boundary).
    assign apply    = (state_q == ST_IDLE) || boundary;

    // Config for the next period. A transfer in the same cycle takes priority.
    // Both sources cannot be present at once because READY is low while staged.
    always_comb begin
        half_n     = half_q;
        dead_n     = dead_q;
        div_n      = div_q;
        stg_half_d = stg_half_q;
        stg_dead_d = stg_dead_q;
        stg_div_d  = stg_div_q;
        stg_vld_d  = stg_vld_q;
        if (apply) begin
            stg_vld_d = 1'b0;
            if (xfer_ok) begin
                half_n = CFG_HALF_IN;
                dead_n = CFG_DEAD_IN;
                div_n  = in_div;
            end else if (stg_vld_q) begin
                half_n = stg_half_q;
                dead_n = stg_dead_q;
                div_n  = stg_div_q;
            end
        end else if (xfer_ok) begin
            stg_half_d = CFG_HALF_IN;
            stg_dead_d = CFG_DEAD_IN;
            stg_div_d  = in_div;
            stg_vld_d  = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (EN_IN) begin
                    state_d = ST_PH_MOD;
                    cnt_d   = half_n - ONE;
                end
            end
            ST_PH_MOD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (dead_q != '0) begin
                    state_d = ST_DEAD1;
                    cnt_d   = dead_q - ONE;
                end else begin
                    state_d = ST_PH_MODN;
                    cnt_d   = half_q - ONE;
                end
            end
            ST_DEAD1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = ST_PH_MODN;
                    cnt_d   = half_q - ONE;
                end
            end
            ST_PH_MODN, ST_DEAD2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if ((state_q == ST_PH_MODN) && (dead_q != '0)) begin
                    state_d = ST_DEAD2;
                    cnt_d   = dead_q - ONE;
                end else if (EN_IN) begin
                    state_d = ST_PH_MOD;
                    cnt_d   = half_n - ONE;
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The period counter counts boundaries under the current divider. A new
    // divider restarts the count so MODL phase is defined from that point.
    always_comb begin
        pcnt_d = pcnt_q;
        modl_d = modl_q;
        if (state_d == ST_IDLE) begin
            pcnt_d = '0;
            modl_d = 1'b0;
        end else if (boundary) begin
            if (div_n != div_q) begin
                pcnt_d = '0;
            end else if (pcnt_q >= div_q - ONE) begin
                pcnt_d = '0;
                modl_d = ~modl_q;
            end else begin
                pcnt_d = pcnt_q + ONE;
            end
        end
    end

    // Outputs are registered from the next state. dead_q is correct here
    // because PH_MODN/DEAD2 are never entered on an edge that updates config.
    always_comb begin
        tick_d  = (cnt_d == '0) &&
                  ((state_d == ST_DEAD2) ||
                   ((state_d == ST_PH_MODN) && (dead_q == '0)));
        ready_d = (state_d == ST_IDLE) || !stg_vld_d;
    end

    always_ff @(posedge CLK_IN or negedge RST_N_IN) begin
        if (!RST_N_IN) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            half_q     <= CNT_W'(HALF_DEF);
            dead_q     <= CNT_W'(DEAD_DEF);
            div_q      <= CNT_W'(DIV_DEF);
            stg_half_q <= '0;
            stg_dead_q <= '0;
            stg_div_q  <= '0;
            stg_vld_q  <= 1'b0;
            pcnt_q     <= '0;
            modl_q     <= 1'b0;
            mod_q      <= 1'b0;
            modn_q     <= 1'b0;
            busy_q     <= 1'b0;
            tick_q     <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_n;
            dead_q     <= dead_n;
            div_q      <= div_n;
            stg_half_q <= stg_half_d;
            stg_dead_q <= stg_dead_d;
            stg_div_q  <= stg_div_d;
            stg_vld_q  <= stg_vld_d;
            pcnt_q     <= pcnt_d;
            modl_q     <= modl_d;
            mod_q      <= (state_d == ST_PH_MOD);
            modn_q     <= (state_d == ST_PH_MODN);
            busy_q     <= (state_d != ST_IDLE);
            tick_q     <= tick_d;
            err_q      <= xfer_bad;
            ready_q    <= ready_d;
        end
    end

    assign CLK_OUT_MOD     = mod_q;
    assign CLK_OUT_MODN    = modn_q;
    assign CLK_OUT_MODL    = modl_q;
    assign BUSY_OUT        = busy_q;
    assign PERIOD_TICK_OUT = tick_q;
    assign CFG_ERR_OUT     = err_q;
    assign CFG_READY_OUT   = ready_q;
    assign STATE_DBG_OUT   = state_q;

endmodule
